// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle responder backed by a resettable register array.
// Decodes adr_i against BASE_ADDRESS, inserts WAIT_STATES idle cycles, then acks once.
module wb_slave_mem #(
    parameter int BASE_ADDRESS = 0,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_COUNT   = 16,
    parameter int AU_IN_DATA   = 1,
    parameter int WAIT_STATES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic [7:0]            wr_cnt,
    output logic [7:0]            rd_cnt
);

    localparam int IDX_W = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam logic [ADDR_WIDTH:0] BASE_W = (ADDR_WIDTH+1)'(BASE_ADDRESS);
    localparam logic [ADDR_WIDTH:0] AU_W   = (ADDR_WIDTH+1)'(AU_IN_DATA);
    localparam logic [ADDR_WIDTH:0] CNT_W  = (ADDR_WIDTH+1)'(DATA_COUNT);
    localparam logic [3:0]          WS_W   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic                  we_q, we_d;
    logic                  hit_q, hit_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic [7:0]            wr_cnt_q, wr_cnt_d;
    logic [7:0]            rd_cnt_q, rd_cnt_d;
    logic                  mem_we;

    logic [DATA_COUNT-1:0][DATA_WIDTH-1:0] mem_q;

    // One extra bit on the offset so addresses below the base show up as a set MSB.
    logic [ADDR_WIDTH:0] off, word, rem;
    logic                hit;

    always_comb begin
        off  = {1'b0, adr_i} - BASE_W;
        word = off / AU_W;
        rem  = off % AU_W;
        hit  = !off[ADDR_WIDTH] && (rem == '0) && (word < CNT_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // S_WAIT is always visited so the ack lands WAIT_STATES+1 edges after capture,
    // even with WAIT_STATES=0 (the counter is simply already exhausted).
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        we_d     = we_q;
        hit_d    = hit_q;
        idx_d    = idx_q;
        wdat_d   = wdat_q;
        ack_d    = 1'b0;
        rdat_d   = rdat_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    we_d    = we_i;
                    wdat_d  = dat_i;
                    idx_d   = word[IDX_W-1:0];
                    hit_d   = hit;
                    wcnt_d  = WS_W;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!cyc_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (we_q) begin
                        if (hit_q) begin
                            mem_we   = 1'b1;
                            wr_cnt_d = wr_cnt_q + 8'd1;
                        end
                    end else begin
                        rdat_d = hit_q ? mem_q[idx_q] : '0;
                        if (hit_q) rd_cnt_d = rd_cnt_q + 8'd1;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!stb_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q   <= '0;
            we_q     <= 1'b0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            wdat_q   <= '0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wcnt_q   <= wcnt_d;
            we_q     <= we_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
            wdat_q   <= wdat_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        mem_q        <= '0;
        else if (mem_we) mem_q[idx_q] <= wdat_q;
    end

    assign dat_o  = rdat_q;
    assign ack_o  = ack_q;
    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

endmodule
